// File: rtl/meter_pkg.sv
// Shared constants, types and segment encoder for the parking-meter display.
// Pure definitions; no latency, no flow control.
package meter_pkg;

    localparam logic [13:0] MAX_COUNT  = 14'd9999;
    localparam logic [13:0] LOW_THRESH = 14'd200;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    typedef logic [3:0] bcd_digit_t;

    function automatic logic [6:0] seg_encode(input bcd_digit_t d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/meter_display_bin2bcd.sv
// Clamped sequential double-dabble: 16-cycle LOAD/SHIFT x14/DONE loop, results latched atomically at DONE.
// Free-running, no backpressure; count is sampled only in LOAD.
module bin2bcd_seq
    import meter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] count,
    output logic [15:0] bcd,
    output logic [13:0] value,
    output logic        done
);

    conv_state_t state_q, state_d;
    logic [29:0] shreg_q, shreg_d;
    logic [13:0] cap_q, cap_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] bcd_q, bcd_d;
    logic [13:0] value_q, value_d;
    logic        done_q, done_d;
    logic [29:0] adj;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cap_d   = cap_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        value_d = value_q;
        done_d  = 1'b0;
        adj     = shreg_q;
        case (state_q)
            LOAD: begin
                cap_d   = (count > MAX_COUNT) ? MAX_COUNT : count;
                shreg_d = {16'd0, cap_d};
                cnt_d   = 4'd0;
                state_d = SHIFT;
            end
            SHIFT: begin
                // Upper 16 bits hold the four BCD nibbles being built
                for (int n = 0; n < 4; n++) begin
                    if (adj[14 + 4*n +: 4] >= 4'd5) begin
                        adj[14 + 4*n +: 4] = adj[14 + 4*n +: 4] + 4'd3;
                    end
                end
                shreg_d = {adj[28:0], 1'b0};
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = shreg_q[29:14];
                value_d = cap_q;
                done_d  = 1'b1;
                state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            shreg_q <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            value_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            value_q <= value_d;
            done_q  <= done_d;
        end
    end

    assign bcd   = bcd_q;
    assign value = value_q;
    assign done  = done_q;

endmodule

// File: rtl/meter_display.sv
// 4-digit multiplexed 7-seg driver with low-time/expiry blink; outputs registered, count->display <=32+1 cycles.
// No backpressure. Optional LEADING_ZERO_BLANK_EN darkens leading zero digits 3..1.
module meter_display
    import meter_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] count,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [15:0] bcd;
    logic [13:0] value;
    logic        unused_done;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .count (count),
        .bcd   (bcd),
        .value (value),
        .done  (unused_done)
    );

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         dig_q, dig_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [1:0]         ph_q, ph_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    bcd_digit_t         digit_sel;
    logic               lit;
`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0]         lead_zero;
`endif

    always_comb begin
        scan_cnt_d  = scan_cnt_q + 1'b1;
        dig_d       = dig_q;
        blink_cnt_d = blink_cnt_q + 1'b1;
        ph_d        = ph_q;
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            dig_d      = dig_q + 2'd1;
        end
        if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            ph_d        = ph_q + 2'd1;
        end
    end

    always_comb begin
        digit_sel = bcd[{dig_q, 2'b00} +: 4];
        if (value == 14'd0) begin
            lit = ~ph_q[0];
        end else if (value < LOW_THRESH) begin
            lit = ~ph_q[1];
        end else begin
            lit = 1'b1;
        end
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is a leading zero if it and everything above it is zero; digit 0 never is
        lead_zero[3] = (bcd[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (bcd[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (bcd[7:4] == 4'd0);
        lead_zero[0] = 1'b0;
        if (lead_zero[dig_q]) begin
            lit = 1'b0;
        end
`endif
        an_d  = lit ? ~(4'b0001 << dig_q) : 4'b1111;
        seg_d = seg_encode(digit_sel);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q  <= '0;
            dig_q       <= '0;
            blink_cnt_q <= '0;
            ph_q        <= '0;
            an_q        <= 4'b1111;
            seg_q       <= SEG_BLANK;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            dig_q       <= dig_d;
            blink_cnt_q <= blink_cnt_d;
            ph_q        <= ph_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_meter_display.sv
// Directed bench for meter_display with a time-based reference model checked every cycle.
module tb_meter_display;

    localparam int SD = 4;
    localparam int BD = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] count = 14'd0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    meter_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .count (count),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: k edges since reset release; display value changes every 16 edges,
    // value sampled 15 edges earlier; digit/phase indices are plain integer divisions of k.
    int         m_k    = 0;
    int         m_cap  = 0;
    int         m_disp = 0;
    logic [3:0] exp_an  = 4'hF;
    logic [6:0] exp_seg = 7'h7F;

    function automatic logic [10:0] model_out(input int k, input int disp);
        int  dig, ph, p10, digit;
        bit  on;
        dig   = (k / SD) % 4;
        ph    = (k / BD) % 4;
        p10   = (dig == 0) ? 1 : (dig == 1) ? 10 : (dig == 2) ? 100 : 1000;
        digit = (disp / p10) % 10;
        if (disp == 0)        on = (ph % 2) == 0;
        else if (disp < 200)  on = ((ph / 2) % 2) == 0;
        else                  on = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        if (dig > 0 && disp < p10) on = 1'b0;
`endif
        return {(on ? ~(4'b0001 << dig) : 4'b1111), seg_tab[digit]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k = 0; m_cap = 0; m_disp = 0;
            exp_an = 4'hF; exp_seg = 7'h7F;
        end else begin
            {exp_an, exp_seg} = model_out(m_k, m_disp);
            m_k++;
            if (m_k % 16 == 1) m_cap = (int'(count) > 9999) ? 9999 : int'(count);
            if (m_k % 16 == 0) m_disp = m_cap;
        end
    end

    always @(negedge clk) begin
        check("an", int'(an), int'(exp_an));
        check("seg", int'(seg), int'(exp_seg));
        check("dp", int'(dp), 1);
    end

    int         obs_lit;
    int         obs_on  [4];
    logic [6:0] obs_seg [4];

    task automatic observe(input int n);
        obs_lit = 0;
        for (int i = 0; i < 4; i++) begin obs_on[i] = 0; obs_seg[i] = 7'h7F; end
        repeat (n) begin
            @(negedge clk);
            if (an != 4'hF) obs_lit++;
            for (int i = 0; i < 4; i++) begin
                if (!an[i]) begin obs_on[i]++; obs_seg[i] = seg; end
            end
        end
    endtask

    initial begin
        count = 14'd1234;
        repeat (3) @(negedge clk);
        check("rst_an", int'(an), 4'hF);
        check("rst_seg", int'(seg), 7'h7F);
        check("rst_dp", int'(dp), 1);
        rst_n = 1'b1;

        repeat (40) @(negedge clk);
        observe(16);
        check("d1234_seg3", int'(obs_seg[3]), 7'b1111001);
        check("d1234_seg2", int'(obs_seg[2]), 7'b0100100);
        check("d1234_seg1", int'(obs_seg[1]), 7'b0110000);
        check("d1234_seg0", int'(obs_seg[0]), 7'b0011001);
        for (int i = 0; i < 4; i++) check("d1234_on", obs_on[i], 4);

        count = 14'd12000;
        repeat (40) @(negedge clk);
        observe(16);
        check("clamp_lit", obs_lit, 16);
        for (int i = 0; i < 4; i++) check("clamp_seg", int'(obs_seg[i]), 7'b0010000);

        count = 14'd150;
        repeat (40) @(negedge clk);
        observe(128);
        check("low_seg2", int'(obs_seg[2]), 7'b1111001);
        check("low_seg1", int'(obs_seg[1]), 7'b0010010);
        check("low_seg0", int'(obs_seg[0]), 7'b1000000);
`ifdef LEADING_ZERO_BLANK_EN
        check("low_lit", obs_lit, 48);
        check("low_on3", obs_on[3], 0);
`else
        check("low_lit", obs_lit, 64);
        check("low_seg3", int'(obs_seg[3]), 7'b1000000);
`endif

        count = 14'd0;
        repeat (40) @(negedge clk);
        observe(64);
        check("zero_seg0", int'(obs_seg[0]), 7'b1000000);
`ifdef LEADING_ZERO_BLANK_EN
        check("zero_lit", obs_lit, 8);
        check("zero_on321", obs_on[1] + obs_on[2] + obs_on[3], 0);
`else
        check("zero_lit", obs_lit, 32);
        check("zero_seg3", int'(obs_seg[3]), 7'b1000000);
`endif

        // Align so the next edge is a LOAD, then change count during the 5th SHIFT
        for (int i = 0; i < 20 && (m_k % 16) != 0; i++) @(negedge clk);
        check("align_load", m_k % 16, 0);
        count = 14'd5000;
        repeat (5) @(negedge clk);
        count = 14'd4999;
        repeat (10) @(negedge clk);
        check("mid_before", int'(dut.u_conv.bcd), 16'h0000);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            check("mid_first_bcd", int'(dut.u_conv.bcd), 16'h5000);
            check("mid_first_val", int'(dut.u_conv.value), 5000);
            @(negedge clk);
        end
        check("mid_second_bcd", int'(dut.u_conv.bcd), 16'h4999);
        check("mid_second_val", int'(dut.u_conv.value), 4999);

        // Async reset while digit 2 is on
        repeat (40) @(negedge clk);
        for (int i = 0; i < 64 && an != 4'b1011; i++) @(negedge clk);
        check("dig2_seen", int'(an), 4'b1011);
        #1 rst_n = 1'b0;
        #1;
        check("arst_an", int'(an), 4'hF);
        check("arst_seg", int'(seg), 7'h7F);
        check("arst_bcd", int'(dut.u_conv.bcd), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
